// File: rtl/cpu_pkg.sv
// Shared CPU constants for the fetch front end.
package cpu_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned INST_BYTES = 4;

    localparam logic [DATA_W-1:0] INST_NOP = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and active-low synchronous reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    import cpu_pkg::*;

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (32'(count_q) == DEPTH);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible while count is zero.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_buffer.sv
// IF front end: owns the fetch PC, issues imem requests over req/gnt/rvalid, and buffers
// returned words with their PC; redirects flush the buffer and drop in-flight responses.
module fetch_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W  = cpu_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              stall_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);
    import cpu_pkg::*;

    localparam int unsigned CntW  = $clog2(MAX_OUT + 1);
    localparam int unsigned FCntW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]          out_cnt_q, out_cnt_d;
    logic [CntW-1:0]          drop_cnt_q, drop_cnt_d;
    logic                     start_q, start_d;

    logic                     issue, resp, keep, pop;
    logic [31:0]              live;
    logic [ADDR_W-1:0]        tag_pc;
    logic                     tag_full, tag_empty;
    logic [CntW-1:0]          unused_tag_cnt;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [FCntW-1:0]         fifo_cnt;
    logic                     fifo_empty, unused_fifo_full;

    // Request gating uses registered state only; dropped requests never reach the FIFO.
    always_comb begin
        live       = 32'(fifo_cnt) + 32'(out_cnt_q) - 32'(drop_cnt_q);
        imem_req_o = start_q && !tag_full && (32'(out_cnt_q) < MAX_OUT) && (live < DEPTH);
        issue      = imem_req_o && imem_gnt_i;
        resp       = imem_rvalid_i && !tag_empty;
        keep       = resp && (drop_cnt_q == '0) && !redirect_i;
        pop        = inst_valid_o && !stall_i && !redirect_i;
    end

    always_comb begin
        start_d    = start_i;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fetch_pc_d = fetch_pc_q;
        if (issue && !resp) begin
            out_cnt_d = out_cnt_q + CntW'(1);
        end else if (resp && !issue) begin
            out_cnt_d = out_cnt_q - CntW'(1);
        end
        if (resp && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CntW'(1);
        end
        if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
        end
        // Every request still live after this cycle, including one granted now, becomes a drop.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            drop_cnt_d = out_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_pc_q <= ADDR_W'(PC_RESET);
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            start_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            start_q    <= start_d;
        end
    end

    sync_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (ADDR_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (issue),
        .pop_i   (resp),
        .wdata_i (fetch_pc_q),
        .rdata_o (tag_pc),
        .count_o (unused_tag_cnt),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_inst_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (keep),
        .pop_i   (pop),
        .wdata_i ({tag_pc, imem_rdata_i}),
        .rdata_o (head),
        .count_o (fifo_cnt),
        .full_o  (unused_fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_addr_o  = fetch_pc_q;
    assign inst_valid_o = !fifo_empty;
    assign inst_o       = inst_valid_o ? head[DATA_W-1:0] : DATA_W'(INST_NOP);
    assign pc_o         = inst_valid_o ? head[ADDR_W+DATA_W-1:DATA_W] : ADDR_W'(PC_RESET);
    assign pc_plus4_o   = pc_o + ADDR_W'(INST_BYTES);

    assert property (@(posedge clk_i) disable iff (!rst_i) imem_rvalid_i |-> (out_cnt_q != '0));
    assert property (@(posedge clk_i) disable iff (!rst_i) drop_cnt_q <= out_cnt_q);

endmodule
